// File: rtl/result_buf_pkg.sv
// Shared types and default sizing for the result drain buffer.
package result_buf_pkg;

  localparam int unsigned RB_DATA_W = 32;
  localparam int unsigned RB_DEPTH  = 24;
  localparam int unsigned RB_CNT_W  = 5;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } rb_state_t;

endpackage

// File: rtl/result_buf_mem.sv
// DEPTH x DATA_W result storage: synchronous write, asynchronous read, contents not reset.
module result_buf_mem
  import result_buf_pkg::*;
#(
  parameter int unsigned DATA_W = RB_DATA_W,
  parameter int unsigned DEPTH  = RB_DEPTH,
  parameter int unsigned AW     = RB_CNT_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && (waddr < AW'(DEPTH))) mem[waddr] <= wdata;
  end

  // Read-ahead addresses can run one past the last entry; return zero there.
  always_comb begin
    rdata = '0;
    if (raddr < AW'(DEPTH)) rdata = mem[raddr];
  end

endmodule

// File: rtl/result_drain_buffer.sv
// Result collector that streams stored entries out over valid/ready on a write request.
// Optional RESULT_BUF_CHECKSUM_EN appends a sum-of-entries beat after the data beats.
module result_drain_buffer
  import result_buf_pkg::*;
#(
  parameter int unsigned DATA_W = RB_DATA_W,
  parameter int unsigned DEPTH  = RB_DEPTH,
  parameter int unsigned CNT_W  = RB_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              store,
  input  logic [DATA_W-1:0] store_data,
  input  logic              write_req,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

`ifdef RESULT_BUF_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  rb_state_t         state;
  logic [CNT_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] sum;
  logic              csum_phase;

  logic              store_ok_c;
  logic [CNT_W-1:0]  count_eff_c;
  logic              xfer_c;
  logic              last_data_c;
  logic [CNT_W-1:0]  rd_addr_c;
  logic [DATA_W-1:0] rd_data_c;
  logic [DATA_W-1:0] first_data_c;

  // Store acceptance, effective count for a same-cycle write_req, and read-ahead address.
  always_comb begin
    store_ok_c   = 1'b0;
    count_eff_c  = count;
    xfer_c       = 1'b0;
    last_data_c  = 1'b0;
    rd_addr_c    = '0;
    first_data_c = rd_data_c;
    store_ok_c   = store && !clear && (state == FILL) && (count < CNT_W'(DEPTH));
    if (store_ok_c) count_eff_c = count + CNT_W'(1);
    xfer_c       = out_valid && out_ready;
    last_data_c  = (rd_ptr == count - CNT_W'(1));
    if (state != FILL) rd_addr_c = rd_ptr + CNT_W'(1);
    // A store landing with the write_req at an empty buffer is the first beat itself.
    if (count == '0) first_data_c = store_data;
  end

  result_buf_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (CNT_W)
  ) u_mem (
    .clk   (clk),
    .we    (store_ok_c),
    .waddr (count),
    .wdata (store_data),
    .raddr (rd_addr_c),
    .rdata (rd_data_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      rd_ptr     <= '0;
      sum        <= '0;
      csum_phase <= 1'b0;
      count      <= '0;
      overflow   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (clear) begin
      state      <= FILL;
      rd_ptr     <= '0;
      sum        <= '0;
      csum_phase <= 1'b0;
      count      <= '0;
      overflow   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (store) begin
            if (store_ok_c) count <= count_eff_c;
            else            overflow <= 1'b1;
          end
          if (write_req) begin
            rd_ptr     <= '0;
            sum        <= '0;
            csum_phase <= 1'b0;
            busy       <= 1'b1;
            if (count_eff_c != '0) begin
              state     <= DRAIN;
              out_valid <= 1'b1;
              out_data  <= first_data_c;
              out_last  <= !CSUM_EN && (count_eff_c == CNT_W'(1));
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end

        DRAIN: begin
          if (store) overflow <= 1'b1;
          if (xfer_c) begin
            if (csum_phase || (last_data_c && !CSUM_EN)) begin
              state      <= DONE;
              out_valid  <= 1'b0;
              out_data   <= '0;
              out_last   <= 1'b0;
              csum_phase <= 1'b0;
              done       <= 1'b1;
            end else if (last_data_c) begin
              // Final data beat accepted: present the running sum as one extra beat.
              csum_phase <= 1'b1;
              out_data   <= sum + out_data;
              out_last   <= 1'b1;
            end else begin
              rd_ptr   <= rd_ptr + CNT_W'(1);
              sum      <= sum + out_data;
              out_data <= rd_data_c;
              out_last <= !CSUM_EN && (rd_ptr + CNT_W'(1) == count - CNT_W'(1));
            end
          end
        end

        DONE: begin
          if (store) overflow <= 1'b1;
          state  <= FILL;
          done   <= 1'b0;
          busy   <= 1'b0;
          count  <= '0;
          rd_ptr <= '0;
        end

        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_result_drain_buffer.sv
// Self-checking bench for result_drain_buffer (honours RESULT_BUF_CHECKSUM_EN when defined).
module tb_result_drain_buffer;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        store;
  logic [31:0] store_data;
  logic        write_req;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;
  logic [4:0]  count;
  logic        overflow;

`ifdef RESULT_BUF_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  int n_cmp;
  int n_bad;

  result_drain_buffer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .store      (store),
    .store_data (store_data),
    .write_req  (write_req),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .count      (count),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        st;
    logic [31:0] d;
    logic        wr;
    logic        rdy;
    logic        clr;
    logic        ev;
    logic [31:0] ed;
    logic        el;
    logic        eb;
    logic        edn;
    int          ec;
    logic        eo;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic st, logic [31:0] d, logic wr, logic rdy, logic clr,
                              logic ev, logic [31:0] ed, logic el, logic eb, logic edn,
                              int ec, logic eo);
    vec_t v;
    v.st = st; v.d = d; v.wr = wr; v.rdy = rdy; v.clr = clr;
    v.ev = ev; v.ed = ed; v.el = el; v.eb = eb; v.edn = edn; v.ec = ec; v.eo = eo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clear = 0; store = 0; store_data = '0; write_req = 0; out_ready = 0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    idle();

    // Reset state with clock running
    repeat (3) tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_count", 32'(count), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Backpressure: A, B, C (C stored with the write_req), ready toggling
    vecs.push_back(mk(1, 32'hA, 0, 0, 0,  0, 0,      0,   0, 0, 1, 0));
    vecs.push_back(mk(1, 32'hB, 0, 0, 0,  0, 0,      0,   0, 0, 2, 0));
    vecs.push_back(mk(1, 32'hC, 1, 0, 0,  1, 32'hA,  0,   1, 0, 3, 0));
    vecs.push_back(mk(0, 0,     0, 0, 0,  1, 32'hA,  0,   1, 0, 3, 0));
    vecs.push_back(mk(0, 0,     0, 1, 0,  1, 32'hB,  0,   1, 0, 3, 0));
    vecs.push_back(mk(0, 0,     0, 0, 0,  1, 32'hB,  0,   1, 0, 3, 0));
    vecs.push_back(mk(0, 0,     0, 1, 0,  1, 32'hC,  !CS, 1, 0, 3, 0));
    vecs.push_back(mk(0, 0,     0, 0, 0,  1, 32'hC,  !CS, 1, 0, 3, 0));
`ifdef RESULT_BUF_CHECKSUM_EN
    vecs.push_back(mk(0, 0,     0, 1, 0,  1, 32'h21, 1,   1, 0, 3, 0));
    vecs.push_back(mk(0, 0,     0, 0, 0,  1, 32'h21, 1,   1, 0, 3, 0));
`endif
    vecs.push_back(mk(0, 0,     0, 1, 0,  0, 0,      0,   1, 1, -1, 0));
    vecs.push_back(mk(0, 0,     0, 0, 0,  0, 0,      0,   0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      store = vecs[i].st; store_data = vecs[i].d; write_req = vecs[i].wr;
      out_ready = vecs[i].rdy; clear = vecs[i].clr;
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].ev));
      chk($sformatf("vec%0d_last", i), 32'(out_last), 32'(vecs[i].el));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].eb));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].edn));
      chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].eo));
      if (vecs[i].ev) chk($sformatf("vec%0d_data", i), out_data, vecs[i].ed);
      if (vecs[i].ec >= 0) chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].ec));
    end
    idle();

    // Full drain of 24 entries with ready held high
    for (int i = 1; i <= 24; i++) begin
      store = 1; store_data = 32'(i); tick();
    end
    store = 0; write_req = 1; out_ready = 1;
    tick();
    write_req = 0;
    chk("full_count", 32'(count), 32'd24);
    for (int i = 1; i <= 24; i++) begin
      chk("full_valid", 32'(out_valid), 32'd1);
      chk("full_data", out_data, 32'(i));
      chk("full_last", 32'(out_last), 32'((i == 24) && !CS));
      tick();
    end
`ifdef RESULT_BUF_CHECKSUM_EN
    chk("full_csum_valid", 32'(out_valid), 32'd1);
    chk("full_csum_data", out_data, 32'h12C);
    chk("full_csum_last", 32'(out_last), 32'd1);
    tick();
`endif
    chk("full_done", 32'(done), 32'd1);
    chk("full_done_busy", 32'(busy), 32'd1);
    chk("full_done_valid", 32'(out_valid), 32'd0);
    tick();
    chk("full_after_done", 32'(done), 32'd0);
    chk("full_after_busy", 32'(busy), 32'd0);
    chk("full_after_count", 32'(count), 32'd0);
    idle();

    // Overflow: 25 stores, only 24 kept
    for (int i = 1; i <= 25; i++) begin
      store = 1; store_data = 32'(i); tick();
    end
    store = 0;
    chk("ovf_count", 32'(count), 32'd24);
    chk("ovf_flag", 32'(overflow), 32'd1);
    write_req = 1; out_ready = 1;
    tick();
    write_req = 0;
    for (int i = 1; i <= 24; i++) begin
      chk("ovf_data", out_data, 32'(i));
      tick();
    end
`ifdef RESULT_BUF_CHECKSUM_EN
    chk("ovf_csum_data", out_data, 32'h12C);
    tick();
`endif
    chk("ovf_no_extra_valid", 32'(out_valid), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    idle();
    clear = 1;
    tick();
    clear = 0;
    chk("ovf_clear_flag", 32'(overflow), 32'd0);
    chk("ovf_clear_count", 32'(count), 32'd0);

    // Empty drain
    write_req = 1;
    tick();
    write_req = 0;
    chk("empty_valid", 32'(out_valid), 32'd0);
    chk("empty_done", 32'(done), 32'd1);
    chk("empty_busy", 32'(busy), 32'd1);
    tick();
    chk("empty_done_end", 32'(done), 32'd0);
    chk("empty_busy_end", 32'(busy), 32'd0);

    // Clear after two of five beats
    for (int i = 0; i < 5; i++) begin
      store = 1; store_data = 32'(10 + i); tick();
    end
    store = 0; write_req = 1; out_ready = 1;
    tick();
    write_req = 0;
    chk("clr_beat0", out_data, 32'd10);
    tick();
    chk("clr_beat1", out_data, 32'd11);
    tick();
    chk("clr_beat2_shown", out_data, 32'd12);
    clear = 1; out_ready = 0;
    tick();
    clear = 0;
    chk("clr_valid", 32'(out_valid), 32'd0);
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_busy", 32'(busy), 32'd0);

    // Store while draining, then asynchronous reset mid-drain
    for (int i = 0; i < 3; i++) begin
      store = 1; store_data = 32'(7 + i); tick();
    end
    store = 0; write_req = 1;
    tick();
    write_req = 0; store = 1; store_data = 32'hDEAD;
    tick();
    store = 0;
    chk("drain_store_ovf", 32'(overflow), 32'd1);
    chk("drain_store_count", 32'(count), 32'd3);
    chk("drain_hold_data", out_data, 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data", out_data, 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_after_valid", 32'(out_valid), 32'd0);
    chk("arst_after_count", 32'(count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
